// File: rtl/count_display_pkg.sv
// Shared constants, FSM state type and seven-segment code table for the
// BCD conversion / display block.
package count_display_pkg;

  localparam int BCD_DIGITS  = 5;
  localparam int DISP_DIGITS = 4;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Active-low {g,f,e,d,c,b,a} codes for digits 0..9, entry 0 in the low slot.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
    7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/count_bcd_display_if.sv
// Conversion request/result bundle between the counter side and the
// BCD converter.
interface count_bcd_display_if #(
  parameter int DATA_W = 16
);
  import count_display_pkg::*;

  logic [DATA_W-1:0]       value;
  logic                    start;
  logic                    busy;
  logic                    done;
  logic [4*BCD_DIGITS-1:0] bcd;
  logic                    ovf;

  modport master (output value, start, input busy, done, bcd, ovf);
  modport slave  (input value, start, output busy, done, bcd, ovf);

endinterface

// File: rtl/count_bcd_display_seg7_decoder.sv
// Combinational BCD nibble to active-low seven-segment decoder; non-decimal
// codes produce a blank digit.
module seg7_decoder
  import count_display_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    if (i_bcd <= 4'd9) o_seg = SEG_TABLE[i_bcd];
  end

endmodule

// File: rtl/count_bcd_display.sv
// Binary-to-BCD converter (iterative double-dabble) feeding a 4-digit,
// active-low, multiplexed seven-segment display.
module count_bcd_display
  import count_display_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int SCAN_DIV = 100000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  count_bcd_display_if.slave     bus,
  input  logic                   blank_lz,
  output logic [DISP_DIGITS-1:0] an,
  output logic [6:0]             seg,
  output logic                   dp
);

  localparam int BCD_W    = 4 * BCD_DIGITS;
  localparam int SR_W     = BCD_W + DATA_W;
  localparam int ITER_W   = $clog2(DATA_W + 1);
  localparam int PRESC_W  = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W    = $clog2(DISP_DIGITS);

  state_t              r_state;
  state_t              w_state_next;
  logic [SR_W-1:0]     r_sr;
  logic [SR_W-1:0]     w_sr_adj;
  logic [SR_W-1:0]     w_sr_next;
  logic [ITER_W-1:0]   r_iter;
  logic                w_last_iter;
  logic [BCD_W-1:0]    r_bcd;
  logic                r_ovf;
  logic [PRESC_W-1:0]  r_presc;
  logic [IDX_W-1:0]    r_idx;
  logic [3:0]          w_digit;
  logic                w_lz;
  logic [6:0]          w_seg_dec;
  logic [DISP_DIGITS-1:0] r_an;
  logic [6:0]          r_seg;

  assign w_last_iter = (r_iter == ITER_W'(DATA_W - 1));

  // NOTE: state is written with <= in always_ff so every register samples
  // the pre-edge values; reset is asynchronous and active-low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    case (r_state)
      IDLE:    if (bus.start) w_state_next = SHIFT;
      SHIFT: begin
        bus.busy = 1'b1;
        if (w_last_iter) w_state_next = DONE;
      end
      DONE: begin
        bus.done     = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Double-dabble step: +3 on each BCD column >= 5, then shift left by one.
  always_comb begin
    w_sr_adj = r_sr;
    for (int d = 0; d < BCD_DIGITS; d++) begin
      if (r_sr[DATA_W + 4*d +: 4] >= 4'd5)
        w_sr_adj[DATA_W + 4*d +: 4] = r_sr[DATA_W + 4*d +: 4] + 4'd3;
    end
    w_sr_next = {w_sr_adj[SR_W-2:0], 1'b0};
  end

  // Result registers load on the edge that enters DONE so bcd and done
  // become valid together and the display never sees partial values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sr   <= '0;
      r_iter <= '0;
      r_bcd  <= '0;
      r_ovf  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (bus.start) begin
          r_sr   <= {{BCD_W{1'b0}}, bus.value};
          r_iter <= '0;
        end
        SHIFT: begin
          r_sr   <= w_sr_next;
          r_iter <= r_iter + ITER_W'(1);
          if (w_last_iter) begin
            r_bcd <= w_sr_next[SR_W-1 -: BCD_W];
            r_ovf <= (w_sr_next[SR_W-1 -: 4] != 4'd0);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.bcd = r_bcd;
  assign bus.ovf = r_ovf;

  // Digit select and leading-zero detection over the displayed digits 3..1.
  always_comb begin
    w_digit = r_bcd[3:0];
    w_lz    = 1'b0;
    case (r_idx)
      2'd1: begin w_digit = r_bcd[7:4];   w_lz = (r_bcd[15:4]  == '0); end
      2'd2: begin w_digit = r_bcd[11:8];  w_lz = (r_bcd[15:8]  == '0); end
      2'd3: begin w_digit = r_bcd[15:12]; w_lz = (r_bcd[15:12] == '0); end
      default: ;
    endcase
  end

  seg7_decoder u_dec (
    .i_bcd (w_digit),
    .o_seg (w_seg_dec)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc <= '0;
      r_idx   <= '0;
      r_an    <= '1;
      r_seg   <= SEG_BLANK;
    end else begin
      if (r_presc == PRESC_W'(SCAN_DIV - 1)) begin
        r_presc <= '0;
        r_idx   <= r_idx + IDX_W'(1);
      end else begin
        r_presc <= r_presc + PRESC_W'(1);
      end
      r_an  <= ~(DISP_DIGITS'(1) << r_idx);
      r_seg <= (blank_lz && w_lz) ? SEG_BLANK : w_seg_dec;
    end
  end

  assign an  = r_an;
  assign seg = r_seg;
  assign dp  = 1'b1;

endmodule
